// File: rtl/lut_cfg_pkg.sv
// lut_cfg_pkg
//   Shared types and sizing helpers for the LUT configuration loader.
//   - lut_cfg_state_e : loader FSM states
//   - nchunk()        : config words per truth-table frame
//   - cnt_w()         : word-counter width (never below 1 bit)
package lut_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } lut_cfg_state_e;

   function automatic int nchunk(input int width, input int chunk);
      return (chunk > 0) ? (width / chunk) : 1;
   endfunction

   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/lut_config_loader.sv
// lut_config_loader
//   Streams a LUT truth table in CHUNK-bit words (LSB word first) into a
//   shadow register and commits it to `values` in one step once the frame
//   is complete, so the downstream LUT mux never sees a partial table.
// Ports
//   clk, rst_n        clock, async active-low reset
//   cfg_start         one-cycle request to begin/restart a frame
//   cfg_valid/ready   word handshake; cfg_ready is a pure state decode
//   cfg_data          config word (CHUNK bits)
//   values            committed truth table (WIDTH bits)
//   values_valid      sticky: a table has been committed since reset
//   cfg_done          one-cycle pulse when a new table lands on values
module lut_config_loader
   import lut_cfg_pkg::*;
#(
   parameter int INPUTS = 4,
   parameter int WIDTH  = 1 << INPUTS,
   parameter int CHUNK  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_start,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CHUNK-1:0] cfg_data,
   output logic [WIDTH-1:0] values,
   output logic             values_valid,
   output logic             cfg_done
);

   localparam int NCH = nchunk(WIDTH, CHUNK);
   localparam int CW  = cnt_w(NCH);

   if (WIDTH != (1 << INPUTS) || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $fatal(1, "lut_config_loader: illegal INPUTS/WIDTH/CHUNK combination");
   end

   lut_cfg_state_e   state_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] shadow_q;
   logic [WIDTH-1:0] values_q;
   logic             values_valid_q;
   logic             cfg_done_q;
   logic             accept;
   logic             last_word;

   assign cfg_ready    = (state_q == SHIFT);
   assign accept       = cfg_ready & cfg_valid;
   assign last_word    = (count_q == CW'(NCH - 1));
   assign values       = values_q;
   assign values_valid = values_valid_q;
   assign cfg_done     = cfg_done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         count_q        <= '0;
         shadow_q       <= '0;
         values_q       <= '0;
         values_valid_q <= 1'b0;
         cfg_done_q     <= 1'b0;
      end else begin
         cfg_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cfg_start) begin
                  state_q <= SHIFT;
                  count_q <= '0;
               end
            end
            SHIFT: begin
               if (cfg_start) begin
                  // Restart wins over finishing the frame; a word arriving
                  // with the restart becomes word 0 of the new frame.
                  if (accept) begin
                     shadow_q[0 +: CHUNK] <= cfg_data;
                     count_q <= (NCH > 1) ? CW'(1) : '0;
                  end else begin
                     count_q <= '0;
                  end
               end else if (accept) begin
                  shadow_q[int'(count_q) * CHUNK +: CHUNK] <= cfg_data;
                  if (last_word) begin
                     state_q <= COMMIT;
                     count_q <= '0;
                  end else begin
                     count_q <= count_q + CW'(1);
                  end
               end
            end
            COMMIT: begin
               values_q       <= shadow_q;
               values_valid_q <= 1'b1;
               cfg_done_q     <= 1'b1;
               count_q        <= '0;
               state_q        <= cfg_start ? SHIFT : IDLE;
            end
            default: begin
               state_q <= IDLE;
               count_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lut_config_loader.sv
// tb_lut_config_loader
//   Two loaders: CHUNK=4 (four words per frame) and CHUNK=16 (one word).
//   The reference model is the committed table (cur4/cur16) plus the
//   arithmetic packing of each frame's words; random words and random
//   valid bubbles drive the loads.
module tb_lut_config_loader;

   logic        clk;
   logic        rst_n;

   logic        start4, valid4, ready4, vv4, done4;
   logic [3:0]  data4;
   logic [15:0] values4;

   logic        start16, valid16, ready16, vv16, done16;
   logic [15:0] data16;
   logic [15:0] values16;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] cur4  = '0;
   logic [15:0] cur16 = '0;

   lut_config_loader #(.INPUTS(4), .WIDTH(16), .CHUNK(4)) u_c4 (
      .clk(clk), .rst_n(rst_n), .cfg_start(start4), .cfg_valid(valid4),
      .cfg_ready(ready4), .cfg_data(data4), .values(values4),
      .values_valid(vv4), .cfg_done(done4)
   );

   lut_config_loader #(.INPUTS(4), .WIDTH(16), .CHUNK(16)) u_c16 (
      .clk(clk), .rst_n(rst_n), .cfg_start(start16), .cfg_valid(valid16),
      .cfg_ready(ready16), .cfg_data(data16), .values(values16),
      .values_valid(vv16), .cfg_done(done16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected table: word k carries weight 16^k.
   function automatic logic [15:0] pack4(input logic [3:0] w [4]);
      int acc = 0;
      for (int k = 0; k < 4; k++) acc += int'(w[k]) * (16 ** k);
      return 16'(acc);
   endfunction

   task automatic rand_words(output logic [3:0] w [4]);
      for (int k = 0; k < 4; k++) w[k] = 4'($urandom);
   endtask

   task automatic start_pulse4();
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
   endtask

   // Offer words w[first..upto-1]; bub = percent chance of a valid bubble.
   task automatic feed4(input logic [3:0] w [4], input int first, input int upto,
                        input int bub, output int edges);
      int k;
      k = first;
      edges = 0;
      while (k < upto && edges < 200) begin
         valid4 = (bub == 0) || (int'($urandom_range(0, 99)) >= bub);
         data4  = valid4 ? w[k] : 4'($urandom);
         chk("ready_in_shift", 32'(ready4), 32'd1);
         tick();
         edges++;
         if (valid4) k++;
         chk("values_held", 32'(values4), 32'(cur4));
         chk("no_early_done", 32'(done4), 32'd0);
      end
      valid4 = 1'b0;
      if (k < upto) chk("feed_timeout", 32'(k), 32'(upto));
   endtask

   // Called right after the last word's edge (loader in COMMIT).
   task automatic commit4(input string tag, input logic [15:0] expv, input bit b2b);
      chk({tag, "_gap_ready"}, 32'(ready4), 32'd0);
      chk({tag, "_pre_values"}, 32'(values4), 32'(cur4));
      start4 = b2b;
      tick();
      start4 = 1'b0;
      chk({tag, "_values"}, 32'(values4), 32'(expv));
      chk({tag, "_done"}, 32'(done4), 32'd1);
      chk({tag, "_vv"}, 32'(vv4), 32'd1);
      chk({tag, "_ready_after"}, 32'(ready4), 32'(b2b));
      cur4 = expv;
      if (!b2b) begin
         tick();
         chk({tag, "_done_drop"}, 32'(done4), 32'd0);
      end
   endtask

   initial begin
      logic [3:0]  w [4];
      logic [3:0]  w2 [4];
      logic [15:0] word;
      int          e;

      rst_n = 1'b0;
      start4 = 0; valid4 = 0; data4 = '0;
      start16 = 0; valid16 = 0; data16 = '0;
      start4 = 1'b1;               // ignored while in reset
      repeat (3) tick();
      start4 = 1'b0;
      chk("rst_low_ready", 32'(ready4), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rst_values4", 32'(values4), 32'h0000);
      chk("rst_vv4", 32'(vv4), 32'd0);
      chk("rst_ready4", 32'(ready4), 32'd0);
      chk("rst_done4", 32'(done4), 32'd0);
      chk("rst_values16", 32'(values16), 32'h0000);
      chk("rst_vv16", 32'(vv16), 32'd0);
      chk("rst_ready16", 32'(ready16), 32'd0);
      chk("rst_done16", 32'(done16), 32'd0);

      // valid while IDLE consumes nothing
      valid4 = 1'b1; data4 = 4'h9;
      tick(); tick();
      chk("idle_ready", 32'(ready4), 32'd0);
      valid4 = 1'b0;

      // Basic load: 0xBEEF, values 5 edges after start
      w = '{4'hF, 4'hE, 4'hE, 4'hB};
      start_pulse4();
      feed4(w, 0, 4, 0, e);
      chk("basic_word_edges", 32'(e), 32'd4);
      commit4("basic", pack4(w), 1'b0);

      // Backpressure: 0x1234 with bubbles, 0xBEEF held throughout
      w = '{4'h4, 4'h3, 4'h2, 4'h1};
      start_pulse4();
      feed4(w, 0, 4, 40, e);
      commit4("bubbles", pack4(w), 1'b0);

      // Mid-frame restart: partial frame then 0,A,5,C
      rand_words(w2);
      start_pulse4();
      feed4(w2, 0, 2, 0, e);
      start_pulse4();
      chk("restart_done", 32'(done4), 32'd0);
      w = '{4'h0, 4'hA, 4'h5, 4'hC};
      feed4(w, 0, 4, 20, e);
      commit4("restart", pack4(w), 1'b0);

      // Restart coinciding with a word: that word becomes word 0
      rand_words(w2);
      rand_words(w);
      start_pulse4();
      feed4(w2, 0, 3, 0, e);
      start4 = 1'b1; valid4 = 1'b1; data4 = w[0];
      tick();
      start4 = 1'b0; valid4 = 1'b0;
      feed4(w, 1, 4, 0, e);
      commit4("restart_word", pack4(w), 1'b0);

      // Asynchronous reset between edges, mid-frame
      rand_words(w2);
      start_pulse4();
      feed4(w2, 0, 2, 0, e);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_values", 32'(values4), 32'h0);
      chk("arst_vv", 32'(vv4), 32'd0);
      chk("arst_ready", 32'(ready4), 32'd0);
      chk("arst_done", 32'(done4), 32'd0);
      cur4 = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      rand_words(w);
      start_pulse4();
      feed4(w, 0, 4, 30, e);
      commit4("post_arst", pack4(w), 1'b0);

      // Back-to-back frames: one-cycle ready gap, both commit in order
      rand_words(w);
      rand_words(w2);
      start_pulse4();
      feed4(w, 0, 4, 0, e);
      commit4("b2b_first", pack4(w), 1'b1);
      feed4(w2, 0, 4, 0, e);
      commit4("b2b_second", pack4(w2), 1'b0);

      // Random frames
      for (int f = 0; f < 6; f++) begin
         rand_words(w);
         start_pulse4();
         feed4(w, 0, 4, int'($urandom_range(0, 60)), e);
         commit4("rand_frame", pack4(w), 1'b0);
      end

      // Single-word frames (CHUNK = WIDTH)
      start16 = 1'b1;
      tick();
      start16 = 1'b0;
      chk("c16_ready", 32'(ready16), 32'd1);
      valid16 = 1'b1; data16 = 16'h8001;
      tick();
      valid16 = 1'b0;
      chk("c16_held", 32'(values16), 32'(cur16));
      chk("c16_gap_ready", 32'(ready16), 32'd0);
      tick();
      cur16 = 16'h8001;
      chk("c16_values", 32'(values16), 32'(cur16));
      chk("c16_done", 32'(done16), 32'd1);
      chk("c16_vv", 32'(vv16), 32'd1);
      tick();
      chk("c16_done_drop", 32'(done16), 32'd0);

      for (int f = 0; f < 3; f++) begin
         word = 16'($urandom);
         start16 = 1'b1;
         tick();
         start16 = 1'b0;
         tick();                  // bubble: nothing offered
         chk("c16r_held", 32'(values16), 32'(cur16));
         valid16 = 1'b1; data16 = word;
         tick();
         valid16 = 1'b0;
         tick();
         cur16 = word;
         chk("c16r_values", 32'(values16), 32'(cur16));
         chk("c16r_done", 32'(done16), 32'd1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lut_config_loader.md
# lut_config_loader

Configuration front end for one LUT. It accepts a LUT truth table as a stream of CHUNK-bit words over a valid/ready handshake and assembles the words in a shadow register. When the frame is complete, it commits the whole table atomically to the `values` output, which drives the truth-table input of the downstream LUT select mux. The mux therefore never sees a partially loaded table, and it keeps evaluating the previous table for the whole load.

## Interface
- INPUTS, 4, LUT input count; sizes the truth table.
- WIDTH, 1<<INPUTS, truth-table bits; must equal 1<<INPUTS.
- CHUNK, 4, bits per config word; must divide WIDTH; 1 ≤ CHUNK ≤ WIDTH.
- clk  input  1  sole clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; deassert is synchronous to clk (synchronised upstream).
- cfg_start  input  1  one-cycle request to begin (or restart) a frame.
- cfg_valid  input  1  cfg_data holds a word.
- cfg_ready  output  1  loader accepts a word this cycle.
- cfg_data  input  CHUNK  config word; word k fills values bits [k*CHUNK +: CHUNK] (LSB word first).
- values  output  WIDTH  committed truth table to the LUT mux.
- values_valid  output  1  a full table has been committed since reset (sticky).
- cfg_done  output  1  one-cycle pulse in the first cycle a new table appears on values.

## Operation
- NCHUNK = WIDTH/CHUNK words per frame; count width = clog2(NCHUNK), minimum 1.
- A word is accepted when cfg_valid & cfg_ready are both high at a rising edge.
- State machine IDLE / SHIFT / COMMIT:
  - IDLE: cfg_ready=0. cfg_start → SHIFT, count←0.
  - SHIFT: cfg_ready=1. On accept: shadow[count*CHUNK +: CHUNK]←cfg_data, count←count+1. Accepting word NCHUNK-1 → COMMIT.
  - COMMIT: cfg_ready=0. values←shadow, values_valid←1, cfg_done←1 (registered). Next state is SHIFT with count←0 if cfg_start is high this cycle, else IDLE.
- cfg_start in SHIFT restarts the frame: count←0, partial shadow discarded, values untouched. If a word is also accepted that cycle, it is written as word 0 and count←1. The restart has priority over completing the frame.
- cfg_start in IDLE or SHIFT while rst_n is low is ignored.
- values changes only in the COMMIT transition. It is never glitched or partially updated.
- cfg_valid is allowed in IDLE or COMMIT; it is ignored and no word is consumed. Upstream must hold the word until ready.
- Reset (any cycle, including mid-frame or in COMMIT): state=IDLE, count=0, shadow=0, values=0, values_valid=0, cfg_done=0, cfg_ready=0. A partial frame is lost.

## Timing
- cfg_ready is a decode of registered state only. There is no combinational path from cfg_valid or cfg_data.
- Throughput: one word per cycle in SHIFT.
- Latency: cfg_start sampled at edge E0 gives cfg_ready=1 after E0.
  - With back-to-back valid, the final word is accepted at E0+NCHUNK.
  - values, values_valid and cfg_done update at E0+NCHUNK+1.
  - cfg_done drops at E0+NCHUNK+2.
- Back-to-back frames: cfg_start held during COMMIT gives cfg_ready=1 again from E0+NCHUNK+1, a gap of exactly one cycle.
- NCHUNK=1 (CHUNK=WIDTH): SHIFT → COMMIT on the first accepted word.

## Structure
- Package lut_cfg_pkg holds:
  - the state enum (IDLE, SHIFT, COMMIT);
  - the function nchunk(WIDTH, CHUNK);
  - the count-width function.
- Parameter legality (WIDTH == 1<<INPUTS, WIDTH % CHUNK == 0) is checked at elaboration with a fatal error.
- No sub-module. The FSM, counter, shadow register and commit register sit in one module of roughly 150–250 lines.

## Test plan
- Reset values: hold rst_n low, then release → values=0x0000, values_valid=0, cfg_ready=0, cfg_done=0.
- Basic load (INPUTS=4, CHUNK=4): cfg_start, then words 0xF, 0xE, 0xE, 0xB back-to-back → values=0xBEEF exactly 5 edges after start; one-cycle cfg_done; values_valid=1.
- Backpressure and holding: insert cfg_valid=0 bubbles between words → same result. values stays at the old table (0xBEEF) throughout the second load of 0x1234, until COMMIT.
- Mid-frame restart: load 2 words, pulse cfg_start, send 0x0, 0xA, 0x5, 0xC → values=0xC5A0. No commit from the aborted frame.
- Async reset mid-frame: assert rst_n asynchronously after word 2 (not on a clock edge) → outputs clear immediately. The next full frame loads correctly.
- Back-to-back frames and NCHUNK=1: cfg_start held in COMMIT → cfg_ready gap of one cycle, and both tables commit in order. With CHUNK=16, one word 0x8001 → values=0x8001 after 2 edges.
